// File: rtl/io_channels_pkg.sv
// Shared definitions for the CPU input/output channel block: default data
// width and width helpers used by the top and the per-channel FIFO.
package io_channels_pkg;

    localparam int DefaultMemoryElementWidth = 12;

    // Pointer width for a power-of-two depth; never collapses to zero bits.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold every value 0..depth inclusive.
    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Channel selector width; a single channel still gets one select bit.
    function automatic int selWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Response returned to the CPU for an `in` request.
    typedef struct packed {
        logic                                 ack;
        logic                                 valid;
        logic [DefaultMemoryElementWidth-1:0] data;
    } response_t;

endpackage

// File: rtl/channel_fifo.sv
// One host-loaded input FIFO. The head word is presented combinationally so
// the top can register it together with the pop that consumes it.
module channel_fifo
    import io_channels_pkg::*;
#(
    parameter  int NIn                = 8,
    parameter  int MemoryElementWidth = DefaultMemoryElementWidth,
    localparam int PtrW               = ptrWidth(NIn),
    localparam int CntW               = countWidth(NIn)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pushValid,
    input  logic [MemoryElementWidth-1:0] pushData,
    output logic                          full,
    input  logic                          popReq,
    output logic [MemoryElementWidth-1:0] popData,
    output logic                          popValid,
    output logic [CntW-1:0]               count
);

    logic [MemoryElementWidth-1:0] r_mem [NIn];
    logic [PtrW-1:0]               r_readPtr;
    logic [PtrW-1:0]               r_writePtr;
    logic [CntW-1:0]               r_count;
    logic                          w_push;
    logic                          w_pop;

    assign full     = (r_count == CntW'(NIn));
    assign popValid = (r_count != '0);
    assign popData  = r_mem[r_readPtr];
    assign count    = r_count;
    assign w_push   = pushValid && !full;
    assign w_pop    = popReq && popValid;

    // Pointers wrap naturally because the depth is a power of two; a
    // simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readPtr  <= '0;
            r_writePtr <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) r_writePtr <= r_writePtr + 1'b1;
            if (w_pop)  r_readPtr  <= r_readPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left untouched by reset.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_writePtr] <= pushData;
    end

endmodule

// File: rtl/io_channels.sv
// Input channel FIFOs plus the circular output ring that sit between the
// instruction executor and the host. The ring lives here because a push into
// a full ring overwrites the oldest word instead of stalling.
module io_channels
    import io_channels_pkg::*;
#(
    parameter  int MemoryElementWidth = DefaultMemoryElementWidth,
    parameter  int NChannels          = 2,
    parameter  int NIn                = 8,
    parameter  int NOut               = 16,
    localparam int ChW                = selWidth(NChannels),
    localparam int InCntW             = countWidth(NIn),
    localparam int OutPtrW            = ptrWidth(NOut),
    localparam int OutCntW            = countWidth(NOut)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          loadValid,
    input  logic [ChW-1:0]                loadChannel,
    input  logic [MemoryElementWidth-1:0] loadData,
    output logic                          loadReady,
    input  logic                          inReq,
    input  logic [ChW-1:0]                inChannel,
    output logic                          inAck,
    output logic                          inValid,
    output logic [MemoryElementWidth-1:0] inData,
    input  logic                          sizeReq,
    input  logic [ChW-1:0]                sizeChannel,
    output logic                          sizeAck,
    output logic [MemoryElementWidth-1:0] sizeData,
    input  logic                          outReq,
    input  logic [MemoryElementWidth-1:0] outData,
    input  logic                          drainReq,
    output logic                          drainValid,
    output logic [MemoryElementWidth-1:0] drainData,
    output logic [OutCntW-1:0]            outCount,
    output logic                          outOverflow
);

    // Same shape as the package response, sized to this instance's width.
    typedef struct packed {
        logic                          ack;
        logic                          valid;
        logic [MemoryElementWidth-1:0] data;
    } responseT;

    logic [NChannels-1:0]          w_pushValid;
    logic [NChannels-1:0]          w_full;
    logic [NChannels-1:0]          w_popReq;
    logic [NChannels-1:0]          w_popValid;
    logic [MemoryElementWidth-1:0] w_popData [NChannels];
    logic [InCntW-1:0]             w_count   [NChannels];

    logic                          w_loadReady;
    logic                          w_inSelValid;
    logic [MemoryElementWidth-1:0] w_inSelData;
    logic [InCntW-1:0]             w_sizeSel;

    responseT                      r_inResp;
    logic                          r_sizeAck;
    logic [MemoryElementWidth-1:0] r_sizeData;

    logic [MemoryElementWidth-1:0] r_outMem [NOut];
    logic [OutPtrW-1:0]            r_outWrite;
    logic [OutPtrW-1:0]            r_outRead;
    logic [OutCntW-1:0]            r_outCount;
    logic                          r_outOverflow;
    logic                          r_drainValid;
    logic [MemoryElementWidth-1:0] r_drainData;
    logic                          w_outFull;
    logic                          w_drainPop;
    logic                          w_overwrite;

    genvar c;
    generate
        for (c = 0; c < NChannels; c++) begin : g_channel
            assign w_pushValid[c] = loadValid && (loadChannel == ChW'(c));
            assign w_popReq[c]    = inReq && (inChannel == ChW'(c));

            channel_fifo #(
                .NIn                (NIn),
                .MemoryElementWidth (MemoryElementWidth)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .pushValid (w_pushValid[c]),
                .pushData  (loadData),
                .full      (w_full[c]),
                .popReq    (w_popReq[c]),
                .popData   (w_popData[c]),
                .popValid  (w_popValid[c]),
                .count     (w_count[c])
            );
        end
    endgenerate

    // Channel selection; an index matching no channel leaves every
    // selection at its zero default, so out-of-range requests see an
    // empty, never-ready channel.
    always_comb begin
        w_loadReady  = 1'b0;
        w_inSelValid = 1'b0;
        w_inSelData  = '0;
        w_sizeSel    = '0;
        for (int i = 0; i < NChannels; i++) begin
            if (loadChannel == ChW'(i)) w_loadReady = !w_full[i];
            if (inChannel == ChW'(i)) begin
                w_inSelValid = w_popValid[i];
                w_inSelData  = w_popData[i];
            end
            if (sizeChannel == ChW'(i)) w_sizeSel = w_count[i];
        end
    end

    assign loadReady = w_loadReady;

    // `in` response: head word captured at the same edge that pops it, so a
    // load into an empty channel on that edge is not visible yet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inResp <= '0;
        end else begin
            r_inResp.ack   <= inReq;
            r_inResp.valid <= inReq && w_inSelValid;
            r_inResp.data  <= (inReq && w_inSelValid) ? w_inSelData : '0;
        end
    end

    // `inSize` response: count as it stood before this edge's load or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sizeAck  <= 1'b0;
            r_sizeData <= '0;
        end else begin
            r_sizeAck  <= sizeReq;
            r_sizeData <= sizeReq ? MemoryElementWidth'(w_sizeSel) : '0;
        end
    end

    assign w_outFull   = (r_outCount == OutCntW'(NOut));
    assign w_drainPop  = drainReq && (r_outCount != '0);
    assign w_overwrite = outReq && w_outFull && !w_drainPop;

    // Output ring control: a push into a full ring drags the read pointer
    // along and flags overflow, unless a pop on the same edge made room.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_outWrite    <= '0;
            r_outRead     <= '0;
            r_outCount    <= '0;
            r_outOverflow <= 1'b0;
            r_drainValid  <= 1'b0;
            r_drainData   <= '0;
        end else begin
            r_drainValid <= w_drainPop;
            r_drainData  <= w_drainPop ? r_outMem[r_outRead] : '0;
            if (outReq) r_outWrite <= r_outWrite + 1'b1;
            if (w_drainPop || w_overwrite) r_outRead <= r_outRead + 1'b1;
            if (w_overwrite) r_outOverflow <= 1'b1;
            if (outReq && !w_drainPop && !w_outFull) begin
                r_outCount <= r_outCount + 1'b1;
            end else if (!outReq && w_drainPop) begin
                r_outCount <= r_outCount - 1'b1;
            end
        end
    end

    // Ring storage, not cleared by reset.
    always_ff @(posedge clock) begin
        if (outReq) r_outMem[r_outWrite] <= outData;
    end

    assign inAck       = r_inResp.ack;
    assign inValid     = r_inResp.valid;
    assign inData      = r_inResp.data;
    assign sizeAck     = r_sizeAck;
    assign sizeData    = r_sizeData;
    assign drainValid  = r_drainValid;
    assign drainData   = r_drainData;
    assign outCount    = r_outCount;
    assign outOverflow = r_outOverflow;

endmodule

// File: doc/io_channels.md
Name: io_channels

Overview:
- Parametrised successor to the single fixed input/output area used by the program-test harness.
- Provides NChannels independent input FIFOs, each loaded by the host and consumed by the CPU `in` and `inSize` operations.
- Provides one circular output channel, written by `out` and drained by the host.
- Sits between the instruction executor and the test bench/FPGA host. Replaces the static inMem/outMem arrays and position counters.

Parameters:
- MemoryElementWidth, 12, data word width (matches localMem/heapMem).
- NChannels, 2, number of input channels (>=1).
- NIn, 8, depth of each input FIFO in words (power of 2, >=2).
- NOut, 16, depth of output ring in words (power of 2, >=2).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- loadValid  in  1  host offers a word to an input channel.
- loadChannel  in  $clog2(NChannels)  target input channel.
- loadData  in  MemoryElementWidth  word to load.
- loadReady  out  1  target channel not full (combinational from loadChannel).
- inReq  in  1  CPU `in` request.
- inChannel  in  $clog2(NChannels)  channel read by `in`.
- inAck  out  1  one-cycle pulse, cycle after inReq.
- inValid  out  1  with inAck: 1 = word delivered, 0 = channel was empty.
- inData  out  MemoryElementWidth  delivered word; 0 when inValid=0.
- sizeReq  in  1  CPU `inSize` request.
- sizeChannel  in  $clog2(NChannels)  channel queried.
- sizeAck  out  1  one-cycle pulse, cycle after sizeReq.
- sizeData  out  MemoryElementWidth  words remaining, zero-extended.
- outReq  in  1  CPU `out` request.
- outData  in  MemoryElementWidth  word to emit.
- drainReq  in  1  host pops oldest output word.
- drainValid  out  1  registered: drainData holds a popped word.
- drainData  out  MemoryElementWidth  popped output word.
- outCount  out  $clog2(NOut+1)  words held in output ring.
- outOverflow  out  1  sticky: an `out` overwrote an unread word.

Behaviour:
- Reset (async, any time, including mid-operation):
  - All FIFO pointers and counts become 0.
  - All ack/valid outputs become 0; inData, sizeData and drainData become 0.
  - outOverflow becomes 0. outCount becomes 0.
  - FIFO storage is not cleared.
- Per input channel: readPtr, writePtr of $clog2(NIn) bits, wrapping modulo NIn; count of $clog2(NIn+1) bits.
- Load:
  - Accepted when loadValid && count<NIn: store at writePtr, then increment.
  - When full, the word is dropped and loadReady=0. Dropping is a bench error, not an RTL fault.
- `in`, 1-cycle latency:
  - inReq at edge N gives inAck=1 in cycle N+1.
  - If count>0 at edge N: inValid=1, inData=mem[readPtr], and readPtr/count advance.
  - If count=0: inValid=0, inData=0, and no state changes.
- `inSize`, 1-cycle latency: sizeData = count sampled before any update at the same edge.
- Simultaneous load, `in` and `inSize` on the same channel and edge:
  - All see pre-edge state.
  - Count is net unchanged when both load and read succeed.
  - Reading an empty channel while loading it returns inValid=0; there is no bypass.
- inReq and sizeReq may be asserted together on any channels.
- Out-of-range channel index (>=NChannels):
  - loadReady=0 and the load is ignored.
  - `in` acks with inValid=0. `inSize` returns 0.
- Output ring:
  - outReq writes outData at outWrite, and outWrite wraps modulo NOut.
  - When full, outReq overwrites the oldest word, advances the read pointer too, sets outOverflow, and leaves outCount at NOut. This matches the existing modulo-NOut behaviour.
- Drain:
  - drainReq with outCount>0 gives drainValid=1 and drainData=oldest word next cycle.
  - drainReq with outCount=0 gives drainValid=0.
- outReq and drainReq on the same edge:
  - Pop occurs and push occurs; count is unchanged.
  - If the ring was full, the pop returns the oldest word and no overflow occurs.
  - If the ring was empty, drainValid=0 and the push lands.
- Ack pulses never exceed one cycle per request. Back-to-back requests produce back-to-back acks.

Decomposition:
- Shared package io_channels_pkg:
  - MemoryElementWidth default.
  - Localparam helpers for pointer/count widths.
  - Response struct {ack, valid, data}.
- Sub-module channel_fifo (one per input channel, generate loop):
  - Ports: clock, reset, push/data/full, pop/data/valid, count.
  - Parametrised by NIn and MemoryElementWidth.
- The output ring stays in the top module because it has overwrite semantics.

Test Plan:
- Load ch0 with 88,44; inSize ch0 -> 2; in, in -> (88,v=1),(44,v=1); inSize -> 0; in -> inValid=0, inData=0.
- Two channels: load ch0=5, ch1=7,9; in ch1 and inSize ch0 in the same cycle -> inData=7, sizeData=1; ch1 count then 1.
- Fill ch0 with NIn words -> loadReady=0; extra load dropped; read all NIn -> order preserved, pointers wrap. Repeat 3 rounds.
- Empty ch0: load 3 and `in` on the same edge -> inValid=0; next `in` -> 3.
- `out` NOut+2 words 1..NOut+2 -> outOverflow=1, outCount=NOut; drain -> 3..NOut+2 in order, then drainValid=0.
- Reset asserted mid-load (ch0 count=4) and mid-drain -> all counts 0, acks 0, outOverflow 0 immediately; inSize ch0 after release -> 0.
